// File: rtl/window_gen_3x3_pkg.sv
// Shared pixel/window types for the 3x3 window generator.
package window_gen_3x3_pkg;
   localparam int WIN = 3;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] grn;
      logic [7:0] blu;
   } pixel_t;

   typedef pixel_t [WIN-1:0][WIN-1:0] chunk_t;

   function automatic int coord_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / chunk-out stream bundle; master is the source/sink side, slave the generator.
interface window_gen_3x3_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
);
   import window_gen_3x3_pkg::*;
   localparam int RW = coord_w(IMG_H);
   localparam int CW = coord_w(IMG_W);

   pixel_t        pix_i;
   logic          sof_i;
   logic          pix_valid_i;
   logic          pix_ready_o;
   chunk_t        chunk_o;
   logic [RW-1:0] chunk_row_o;
   logic [CW-1:0] chunk_col_o;
   logic          chunk_valid_o;
   logic          chunk_ready_i;

   modport master (
      output pix_i, sof_i, pix_valid_i, chunk_ready_i,
      input  pix_ready_o, chunk_o, chunk_row_o, chunk_col_o, chunk_valid_o
   );

   modport slave (
      input  pix_i, sof_i, pix_valid_i, chunk_ready_i,
      output pix_ready_o, chunk_o, chunk_row_o, chunk_col_o, chunk_valid_o
   );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One line of pixels: single write port and an asynchronous read port sharing one address.
module window_gen_3x3_line_buffer
   import window_gen_3x3_pkg::*;
#(
   parameter  int DEPTH = 640,
   localparam int AW    = coord_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wdata,
   output pixel_t        rdata
);
   pixel_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 window stream; one chunk per interior pixel,
// built from two line buffers feeding a 3-column shift window.
module window_gen_3x3
   import window_gen_3x3_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input logic            clk,
   input logic            rst,
   window_gen_3x3_if.slave bus
);
   localparam int RW = coord_w(IMG_H);
   localparam int CW = coord_w(IMG_W);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

   logic [RW-1:0] r, r_cur, chunk_row;
   logic [CW-1:0] c, c_cur, chunk_col;
   chunk_t        win, win_nxt;
   pixel_t        lb0_q, lb1_q;
   logic          pix_ready, accept, emit, chunk_valid;

   assign pix_ready = !chunk_valid || bus.chunk_ready_i;
   assign accept    = bus.pix_valid_i && pix_ready;

   always_comb begin
      // sof forces the accepted pixel to (0,0) whatever the counters say
      r_cur   = bus.sof_i ? '0 : r;
      c_cur   = bus.sof_i ? '0 : c;
      win_nxt = win;
      for (int i = 0; i < WIN; i++) begin
         for (int j = 0; j < WIN - 1; j++) win_nxt[i][j] = win[i][j+1];
      end
      win_nxt[0][WIN-1] = lb1_q;
      win_nxt[1][WIN-1] = lb0_q;
      win_nxt[2][WIN-1] = bus.pix_i;
      emit = accept && (r_cur >= RW'(2)) && (c_cur >= CW'(2));
   end

   // lb0 holds row r-1, lb1 row r-2; the old lb0 entry ages into lb1
   window_gen_3x3_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (c_cur),
      .wdata (bus.pix_i),
      .rdata (lb0_q)
   );

   window_gen_3x3_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (c_cur),
      .wdata (lb0_q),
      .rdata (lb1_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r           <= '0;
         c           <= '0;
         win         <= '0;
         chunk_valid <= 1'b0;
         chunk_row   <= '0;
         chunk_col   <= '0;
      end else begin
         if (accept) begin
            win <= win_nxt;
            if (c_cur == C_LAST) begin
               c <= '0;
               r <= (r_cur == R_LAST) ? '0 : r_cur + RW'(1);
            end else begin
               c <= c_cur + CW'(1);
               r <= r_cur;
            end
         end
         if (emit) begin
            chunk_valid <= 1'b1;
            chunk_row   <= r_cur - RW'(1);
            chunk_col   <= c_cur - CW'(1);
         end else if (bus.chunk_ready_i) begin
            chunk_valid <= 1'b0;
         end
      end
   end

   // window only moves on accept, which while valid implies the chunk was taken
   assign bus.pix_ready_o   = pix_ready;
   assign bus.chunk_valid_o = chunk_valid;
   assign bus.chunk_o       = win;
   assign bus.chunk_row_o   = chunk_row;
   assign bus.chunk_col_o   = chunk_col;
endmodule
